// File: rtl/qpsk_rx_controller_if.sv
// Byte stream handshake from the QPSK receive sequencer to framing.
// master drives data/valid, slave returns ready.
interface qpsk_rx_controller_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/qpsk_rx_controller.sv
// QPSK receive sequencer: lock wait, symbol decimation, sync hunt, byte pack.
// Define QPSK_RX_CRC_EN to add the CRC-8 frame check and crc_ok output.
module qpsk_rx_controller #(
    parameter int unsigned SPS           = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hE41B,
    parameter int unsigned PAYLOAD_BYTES = 64,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [31:0]                 fcw_cfg,
    output logic [31:0]                 fcw_out,
    input  logic                        demod_locked,
    input  logic [1:0]                  demod_symbol,
    input  logic                        demod_symbol_valid,
    qpsk_rx_controller_if.master        byte_if,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        rx_error,
`ifdef QPSK_RX_CRC_EN
    output logic                        crc_ok,
`endif
    output logic [2:0]                  state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] HUNT      = 3'd2;
    localparam logic [2:0] RECEIVE   = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;

    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PW-1:0] TAKE_PH   = PW'(SPS / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]    LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   fcw_q, fcw_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    // Only the last 7 symbols need keeping; the 8th is the incoming one.
    logic [13:0]   sync_q, sync_d;
    logic [15:0]   sync_sh;
    logic [2:0]    nsym_q, nsym_d;
    logic [1:0]    sym_q, sym_d;
    logic [5:0]    part_q, part_d;
    logic [7:0]    bcnt_q, bcnt_d;
    logic [7:0]    bdata_q, bdata_d;
    logic [7:0]    new_byte;
    logic          bvalid_q, bvalid_d;
    logic          fs_q, fs_d;
    logic          fd_q, fd_d;
    logic          err_q, err_d;
    logic          take;
    logic          lost;

`ifdef QPSK_RX_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_ok_q, crc_ok_d;

    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        fcw_d    = fcw_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        sync_d   = sync_q;
        nsym_d   = nsym_q;
        sym_d    = sym_q;
        part_d   = part_q;
        bcnt_d   = bcnt_q;
        bdata_d  = bdata_q;
        bvalid_d = bvalid_q;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        err_d    = 1'b0;
`ifdef QPSK_RX_CRC_EN
        crc_d    = crc_q;
        crc_ok_d = 1'b0;
`endif
        take     = demod_symbol_valid && (phase_q == TAKE_PH);
        sync_sh  = {sync_q, demod_symbol};
        new_byte = {part_q, demod_symbol};
        lost     = !demod_locked &&
                   (state_q == HUNT || state_q == RECEIVE ||
                    state_q == DRAIN);

        if (demod_symbol_valid) phase_d = phase_q + 1'b1;
        if (bvalid_q && byte_if.byte_ready) bvalid_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = '0;
            sync_d  = '0;
            nsym_d  = '0;
            sym_d   = '0;
            part_d  = '0;
            bcnt_d  = '0;
        end else if (lost) begin
            state_d = WAIT_LOCK;
            err_d   = 1'b1;
            cnt_d   = '0;
            sym_d   = '0;
            part_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_LOCK;
                    fcw_d   = fcw_cfg;
                    cnt_d   = '0;
                end
                WAIT_LOCK: begin
                    if (demod_locked) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                        phase_d = '0;
                        sync_d  = '0;
                        nsym_d  = '0;
                    end else if (cnt_q == TO_LAST) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HUNT: begin
                    if (take) begin
                        sync_d = sync_sh[13:0];
                        if (nsym_q != 3'd7) nsym_d = nsym_q + 1'b1;
                        if (sync_sh == SYNC_WORD && nsym_q == 3'd7) begin
                            state_d = RECEIVE;
                            fs_d    = 1'b1;
                            sym_d   = '0;
                            part_d  = '0;
                            bcnt_d  = '0;
`ifdef QPSK_RX_CRC_EN
                            crc_d   = '0;
`endif
                        end
                    end
                end
                RECEIVE: begin
                    if (take) begin
                        part_d = {part_q[3:0], demod_symbol};
                        sym_d  = sym_q + 1'b1;
                        if (sym_q == 2'd3) begin
                            part_d = '0;
                            // Held byte not taken this cycle: drop the new one.
                            if (bvalid_q && !byte_if.byte_ready) begin
                                err_d = 1'b1;
                            end else begin
                                bdata_d  = new_byte;
                                bvalid_d = 1'b1;
                            end
`ifdef QPSK_RX_CRC_EN
                            crc_d = crc8_byte(crc_q, new_byte);
`endif
                            if (bcnt_q == LAST_BYTE) begin
                                bcnt_d  = '0;
                                state_d = DRAIN;
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!bvalid_q) begin
                        fd_d    = 1'b1;
                        state_d = HUNT;
                        phase_d = '0;
                        sync_d  = '0;
                        nsym_d  = '0;
`ifdef QPSK_RX_CRC_EN
                        crc_ok_d = (crc_q == 8'h00);
                        if (crc_q != 8'h00) err_d = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            fcw_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            sync_q   <= '0;
            nsym_q   <= '0;
            sym_q    <= '0;
            part_q   <= '0;
            bcnt_q   <= '0;
            bdata_q  <= '0;
            bvalid_q <= 1'b0;
            fs_q     <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef QPSK_RX_CRC_EN
            crc_q    <= '0;
            crc_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fcw_q    <= fcw_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sync_q   <= sync_d;
            nsym_q   <= nsym_d;
            sym_q    <= sym_d;
            part_q   <= part_d;
            bcnt_q   <= bcnt_d;
            bdata_q  <= bdata_d;
            bvalid_q <= bvalid_d;
            fs_q     <= fs_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
`ifdef QPSK_RX_CRC_EN
            crc_q    <= crc_d;
            crc_ok_q <= crc_ok_d;
`endif
        end
    end

    assign fcw_out            = fcw_q;
    assign byte_if.byte_data  = bdata_q;
    assign byte_if.byte_valid = bvalid_q;
    assign frame_start        = fs_q;
    assign frame_done         = fd_q;
    assign rx_error           = err_q;
    assign state              = state_q;
`ifdef QPSK_RX_CRC_EN
    assign crc_ok             = crc_ok_q;
`endif

endmodule

// File: tb/tb_qpsk_rx_controller.sv
// Randomized bench for qpsk_rx_controller against a queue-based model.
// Define QPSK_RX_CRC_EN to also cover crc_ok.
module tb_qpsk_rx_controller;

    localparam int          SPS = 4;
    localparam int          PB  = 2;
    localparam int          LT  = 100;
    localparam logic [15:0] SW  = 16'hE41B;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] fcw_cfg;
    logic [31:0] fcw_out;
    logic        demod_locked;
    logic [1:0]  demod_symbol;
    logic        demod_symbol_valid;
    logic        frame_start;
    logic        frame_done;
    logic        rx_error;
    logic [2:0]  state;
`ifdef QPSK_RX_CRC_EN
    logic        crc_ok;
`endif

    qpsk_rx_controller_if bif();

    qpsk_rx_controller #(
        .SPS(SPS),
        .SYNC_WORD(SW),
        .PAYLOAD_BYTES(PB),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fcw_cfg(fcw_cfg),
        .fcw_out(fcw_out),
        .demod_locked(demod_locked),
        .demod_symbol(demod_symbol),
        .demod_symbol_valid(demod_symbol_valid),
        .byte_if(bif),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .rx_error(rx_error),
`ifdef QPSK_RX_CRC_EN
        .crc_ok(crc_ok),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_st;
    logic [31:0] m_fcw;
    int          m_wait;
    int          m_phase;
    int          m_hist[$];
    int          m_bits[$];
    int          m_nb;
    bit          m_bv;
    logic [7:0]  m_bd;
    bit          m_fs, m_fd, m_err, m_ok, m_took;
    logic [7:0]  m_crc;

    // Stimulus controls
    bit          en_r;
    bit          lk_r;
    int          rdy_mode;
    int          vld_pct;
    logic [31:0] fcw_r;
    int          txq[$];

    function automatic logic [7:0] crc_upd(input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_fcw = '0; m_wait = 0; m_phase = 0;
        m_hist.delete(); m_bits.delete(); m_nb = 0;
        m_bv = 0; m_bd = '0; m_fs = 0; m_fd = 0; m_err = 0; m_ok = 0;
        m_took = 0; m_crc = '0;
    endtask

    task automatic model_step();
        bit         take, bdone, hunt_in;
        int         nst, w;
        logic [7:0] b;
        take    = demod_symbol_valid && (m_phase == SPS / 2 - 1);
        m_took  = take && (m_st == 2 || m_st == 3);
        nst     = m_st;
        m_fs = 0; m_fd = 0; m_err = 0; m_ok = 0;
        bdone = 0; hunt_in = 0; b = '0;
        if (!enable) begin
            nst = 0; m_wait = 0; m_hist.delete(); m_bits.delete(); m_nb = 0;
        end else if (m_st == 0) begin
            nst = 1; m_fcw = fcw_cfg; m_wait = 0;
        end else if (m_st >= 2 && !demod_locked) begin
            m_err = 1; nst = 1; m_wait = 0; m_bits.delete(); m_nb = 0;
        end else if (m_st == 1) begin
            if (demod_locked) begin
                nst = 2; hunt_in = 1;
            end else if (m_wait + 1 >= LT) begin
                m_err = 1; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else if (m_st == 2) begin
            if (take) begin
                m_hist.push_back(int'(demod_symbol));
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                if (m_hist.size() == 8) begin
                    w = 0;
                    foreach (m_hist[i]) w = w * 4 + m_hist[i];
                    if (w == int'(SW)) begin
                        nst = 3; m_fs = 1; m_bits.delete(); m_nb = 0; m_crc = '0;
                    end
                end
            end
        end else if (m_st == 3) begin
            if (take) begin
                m_bits.push_back(int'(demod_symbol));
                if (m_bits.size() == 4) begin
                    b = 8'(m_bits[0] * 64 + m_bits[1] * 16 +
                           m_bits[2] * 4 + m_bits[3]);
                    m_bits.delete();
                    bdone = 1;
                    m_crc = crc_upd(m_crc, b);
                    m_nb++;
                    if (m_nb == PB) begin nst = 4; m_nb = 0; end
                end
            end
        end else if (m_st == 4) begin
            if (!m_bv) begin
                m_fd = 1; nst = 2; hunt_in = 1;
                m_ok = (m_crc == 8'h00);
`ifdef QPSK_RX_CRC_EN
                if (m_crc != 8'h00) m_err = 1;
`endif
            end
        end
        if (bdone && m_bv && !bif.byte_ready) m_err = 1;
        else if (bdone) begin m_bv = 1; m_bd = b; end
        else if (m_bv && bif.byte_ready) m_bv = 0;
        if (hunt_in) m_hist.delete();
        if (hunt_in || !enable) m_phase = 0;
        else if (demod_symbol_valid) m_phase = (m_phase + 1) % SPS;
        m_st = nst;
    endtask

    task automatic compare();
        chk("state", 32'(state), 32'(m_st));
        chk("fcw_out", fcw_out, m_fcw);
        chk("byte_valid", 32'(bif.byte_valid), 32'(m_bv));
        if (m_bv) chk("byte_data", 32'(bif.byte_data), 32'(m_bd));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("rx_error", 32'(rx_error), 32'(m_err));
`ifdef QPSK_RX_CRC_EN
        if (m_fd) chk("crc_ok", 32'(crc_ok), 32'(m_ok));
`endif
    endtask

    task automatic cycle();
        enable       = en_r;
        demod_locked = lk_r;
        fcw_cfg      = fcw_r;
        demod_symbol_valid = (int'($urandom_range(0, 99)) < vld_pct);
        if (m_phase == SPS / 2 - 1 && txq.size() > 0)
            demod_symbol = 2'(txq[0]);
        else
            demod_symbol = 2'($urandom_range(0, 3));
        bif.byte_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1))
                                         : 1'(rdy_mode);
        model_step();
        if (m_took && txq.size() > 0) void'(txq.pop_front());
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic push_sync();
        for (int i = 7; i >= 0; i--)
            txq.push_back(int'((SW >> (2 * i)) & 16'h3));
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--)
            txq.push_back(int'((b >> (2 * i)) & 8'h3));
    endtask

    // Run until the model shows frame_done; returns 1 if seen in budget.
    task automatic run_to_done(input int budget, output bit seen);
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            cycle();
            if (m_fd) seen = 1;
        end
    endtask

    initial begin
        bit         seen, got;
        int         nfs, nerr, nbv, first, k;
        logic [7:0] gb, b0;

        reset = 1'b0;
        enable = 1'b0; demod_locked = 1'b0; demod_symbol = 2'd0;
        demod_symbol_valid = 1'b0; fcw_cfg = 32'hDEAD_BEEF;
        bif.byte_ready = 1'b0;
        en_r = 0; lk_r = 1; rdy_mode = 1; vld_pct = 100;
        fcw_r = 32'h1999_999A;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fcw", fcw_out, 32'd0);
        chk("rst_bvalid", 32'(bif.byte_valid), 32'd0);
        chk("rst_bdata", 32'(bif.byte_data), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(rx_error), 32'd0);
        reset = 1'b1;

        // Enable with lock already present
        en_r = 1;
        cycle();
        chk("en_state1", 32'(state), 32'd1);
        chk("en_fcw", fcw_out, 32'h1999_999A);
        cycle();
        chk("en_state2", 32'(state), 32'd2);

        // Sync then payload 1,2,3,0 -> 0x6C
        push_sync();
        push_byte(8'h6C);
        push_byte(8'($urandom_range(0, 255)));
        nfs = 0; got = 0; gb = '0; seen = 0;
        for (k = 0; k < 400 && !seen; k++) begin
            cycle();
            if (frame_start) nfs++;
            if (bif.byte_valid && !got) begin got = 1; gb = bif.byte_data; end
            if (m_fd) seen = 1;
        end
        chk("t1_done_seen", 32'(seen), 32'd1);
        chk("t1_fstart_cnt", 32'(nfs), 32'd1);
        chk("t1_byte", 32'(gb), 32'h6C);
        chk("t1_state", 32'(state), 32'd2);

        // Overflow: ready held low
        rdy_mode = 0;
        push_sync();
        push_byte(8'($urandom_range(0, 255)));
        push_byte(8'($urandom_range(0, 255)));
        nerr = 0;
        for (k = 0; k < 400 && m_st != 4; k++) begin
            cycle();
            if (rx_error) nerr++;
        end
        repeat (20) begin
            cycle();
            if (rx_error) nerr++;
        end
        chk("ovf_state", 32'(state), 32'd4);
        chk("ovf_err_cnt", 32'(nerr), 32'd1);
        chk("ovf_held", 32'(bif.byte_valid), 32'd1);
        rdy_mode = 1;
        run_to_done(20, seen);
        chk("ovf_done_seen", 32'(seen), 32'd1);

        // Lock lost after two payload symbols
        push_sync();
        push_byte(8'($urandom_range(0, 255)));
        push_byte(8'($urandom_range(0, 255)));
        for (k = 0; k < 400 && !(m_st == 3 && m_bits.size() == 2); k++)
            cycle();
        chk("ll_reach", 32'(m_bits.size()), 32'd2);
        lk_r = 0;
        cycle();
        chk("ll_state", 32'(state), 32'd1);
        chk("ll_err", 32'(rx_error), 32'd1);
        txq.delete();
        nbv = 0; nfs = 0;
        repeat (10) begin
            cycle();
            if (bif.byte_valid) nbv++;
            if (frame_done) nfs++;
        end
        chk("ll_no_byte", 32'(nbv), 32'd0);
        chk("ll_no_done", 32'(nfs), 32'd0);

        // Lock timeout
        en_r = 0;
        cycle();
        en_r = 1;
        cycle();
        nerr = 0; first = -1;
        for (int j = 1; j <= 250; j++) begin
            cycle();
            if (rx_error) begin
                nerr++;
                if (first < 0) first = j;
            end
        end
        chk("to_first", 32'(first), 32'd100);
        chk("to_cnt", 32'(nerr), 32'd2);
        chk("to_state", 32'(state), 32'd1);
        lk_r = 1;
        for (k = 0; k < 10 && m_st != 2; k++) cycle();

`ifdef QPSK_RX_CRC_EN
        push_sync(); push_byte(8'h01); push_byte(8'h07);
        run_to_done(400, seen);
        chk("crc_good_seen", 32'(seen), 32'd1);
        chk("crc_good_ok", 32'(crc_ok), 32'd1);
        chk("crc_good_err", 32'(rx_error), 32'd0);
        push_sync(); push_byte(8'h01); push_byte(8'h06);
        run_to_done(400, seen);
        chk("crc_bad_seen", 32'(seen), 32'd1);
        chk("crc_bad_ok", 32'(crc_ok), 32'd0);
        chk("crc_bad_err", 32'(rx_error), 32'd1);
`endif

        // Random traffic with ready, lock and enable disturbances
        rdy_mode = 2;
        vld_pct  = 70;
        for (int n = 0; n < 2500; n++) begin
            if (txq.size() < 4) begin
                if ($urandom_range(0, 9) < 7) begin
                    push_sync();
                    b0 = 8'($urandom_range(0, 255));
                    push_byte(b0);
                    if ($urandom_range(0, 1) == 1) push_byte(crc_upd(8'h00, b0));
                    else push_byte(8'($urandom_range(0, 255)));
                end else begin
                    repeat (4) txq.push_back(int'($urandom_range(0, 3)));
                end
            end
            lk_r  = ($urandom_range(0, 299) != 0);
            en_r  = ($urandom_range(0, 999) != 0);
            fcw_r = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
